// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchy dispatch node.
package hier_node_pkg;

  localparam int unsigned MAX_CHILD = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COLLECT,
    RESPOND
  } state_t;

  // Single set bit at position idx, or all zeros when idx is outside the child range.
  function automatic logic [MAX_CHILD-1:0] onehot(input int unsigned idx,
                                                  input int unsigned num_child);
    logic [MAX_CHILD-1:0] mask;
    mask = '0;
    if (idx < num_child) mask = MAX_CHILD'(1) << idx;
    return mask;
  endfunction

endpackage

// File: rtl/hier_node_timeout.sv
// Transaction timeout counter: cleared at request acceptance, counts while enabled,
// and flags expiry on the last allowed cycle. LIMIT of 0 never expires.
module hier_node_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: the next-state value is defaulted before any branch so no path leaves it unassigned and infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: non-blocking assignments make every flop take its new value together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = (LIMIT != 0) && en && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/hier_node_dispatch.sv
// Hierarchy node: fans one parent request out to NUM_CHILD children (broadcast or
// sequential), sums their responses, and answers upstream with a timeout/error path.
module hier_node_dispatch
  import hier_node_pkg::*;
#(
  parameter int unsigned NUM_CHILD   = 5,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SEQ_MODE    = 0,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          up_req_valid,
  output logic                          up_req_ready,
  input  logic [DATA_W-1:0]             up_req_data,
  output logic                          up_rsp_valid,
  input  logic                          up_rsp_ready,
  output logic [DATA_W-1:0]             up_rsp_data,
  output logic                          up_rsp_err,
  output logic [NUM_CHILD-1:0]          ch_req_valid,
  input  logic [NUM_CHILD-1:0]          ch_req_ready,
  output logic [DATA_W-1:0]             ch_req_data,
  input  logic [NUM_CHILD-1:0]          ch_rsp_valid,
  output logic [NUM_CHILD-1:0]          ch_rsp_ready,
  input  logic [NUM_CHILD*DATA_W-1:0]   ch_rsp_data,
  output logic                          busy
);

  localparam int unsigned IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

  state_t               state_q, state_d;
  logic [NUM_CHILD-1:0] pend_req_q, pend_req_d;
  logic [NUM_CHILD-1:0] pend_rsp_q, pend_rsp_d;
  logic [NUM_CHILD-1:0] stale_q, stale_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 err_q, err_d;
  logic                 rdy_q, rdy_d;

  logic [NUM_CHILD-1:0] req_hs, rsp_hs;
  logic [DATA_W-1:0]    rsp_sum;
  logic                 tmo_clr, tmo_en, tmo_expire;

  assign ch_req_valid = (state_q == ISSUE) ? pend_req_q : '0;
  // Stale children are drained in every state so a late answer can never land in a new transaction.
  assign ch_rsp_ready = ((state_q == COLLECT) ? pend_rsp_q : '0) | stale_q;
  assign ch_req_data  = data_q;
  assign up_req_ready = rdy_q;
  assign up_rsp_valid = (state_q == RESPOND);
  assign up_rsp_data  = acc_q;
  assign up_rsp_err   = err_q;
  assign busy         = (state_q != IDLE) || (stale_q != '0);

  assign req_hs = ch_req_valid & ch_req_ready;
  assign rsp_hs = ch_rsp_valid & ch_rsp_ready;
  assign tmo_en = (state_q == ISSUE) || (state_q == COLLECT);

  hier_node_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d    = state_q;
    pend_req_d = pend_req_q;
    pend_rsp_d = pend_rsp_q;
    acc_d      = acc_q;
    data_d     = data_q;
    idx_d      = idx_q;
    err_d      = err_q;
    stale_d    = stale_q & ~rsp_hs;
    tmo_clr    = 1'b0;

    rsp_sum = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (rsp_hs[i] && pend_rsp_q[i]) rsp_sum = rsp_sum + ch_rsp_data[i*DATA_W +: DATA_W];
    end

    unique case (state_q)
      IDLE: begin
        if (up_req_valid && rdy_q) begin
          data_d     = up_req_data;
          acc_d      = '0;
          err_d      = 1'b0;
          idx_d      = '0;
          pend_rsp_d = '0;
          pend_req_d = (SEQ_MODE != 0) ? NUM_CHILD'(onehot(0, NUM_CHILD)) : '1;
          tmo_clr    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        pend_req_d = pend_req_q & ~req_hs;
        pend_rsp_d = pend_rsp_q | req_hs;
        if (pend_req_d == '0) state_d = COLLECT;
      end
      COLLECT: begin
        pend_rsp_d = pend_rsp_q & ~rsp_hs;
        acc_d      = acc_q + rsp_sum;
        if (pend_rsp_d == '0) begin
          if ((SEQ_MODE == 0) || (idx_q == IDX_W'(NUM_CHILD - 1))) begin
            state_d = RESPOND;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            pend_req_d = NUM_CHILD'(onehot(32'(idx_q) + 32'd1, NUM_CHILD));
            state_d    = ISSUE;
          end
        end
      end
      RESPOND: begin
        if (up_rsp_ready) state_d = IDLE;
      end
    endcase

    // A normal completion on the expiry cycle wins; otherwise outstanding children turn stale.
    if (tmo_expire && (state_d != RESPOND)) begin
      state_d    = RESPOND;
      err_d      = 1'b1;
      stale_d    = stale_d | pend_rsp_d;
      pend_rsp_d = '0;
      pend_req_d = '0;
    end

    rdy_d = (state_d == IDLE) && (stale_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_req_q <= '0;
      pend_rsp_q <= '0;
      stale_q    <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_req_q <= pend_req_d;
      pend_rsp_q <= pend_rsp_d;
      stale_q    <= stale_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
    end
  end

endmodule

// File: tb/tb_hier_node_dispatch.sv
// Directed bench for hier_node_dispatch: a broadcast node (timeout 8) and a sequential
// node side by side, each driven by a small configurable child responder model.
module tb_hier_node_dispatch;

  localparam int NC = 5;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             up_req_valid [2];
  logic             up_req_ready [2];
  logic [DW-1:0]    up_req_data  [2];
  logic             up_rsp_valid [2];
  logic             up_rsp_ready [2];
  logic [DW-1:0]    up_rsp_data  [2];
  logic             up_rsp_err   [2];
  logic [NC-1:0]    ch_req_valid [2];
  logic [NC-1:0]    ch_req_ready [2];
  logic [DW-1:0]    ch_req_data  [2];
  logic [NC-1:0]    ch_rsp_valid [2];
  logic [NC-1:0]    ch_rsp_ready [2];
  logic [NC*DW-1:0] ch_rsp_data  [2];
  logic             busy         [2];

  hier_node_dispatch #(.NUM_CHILD(NC), .DATA_W(DW), .SEQ_MODE(0), .TIMEOUT_CYC(8)) u_bcast (
    .clk(clk), .rst_n(rst_n),
    .up_req_valid(up_req_valid[0]), .up_req_ready(up_req_ready[0]), .up_req_data(up_req_data[0]),
    .up_rsp_valid(up_rsp_valid[0]), .up_rsp_ready(up_rsp_ready[0]), .up_rsp_data(up_rsp_data[0]),
    .up_rsp_err(up_rsp_err[0]),
    .ch_req_valid(ch_req_valid[0]), .ch_req_ready(ch_req_ready[0]), .ch_req_data(ch_req_data[0]),
    .ch_rsp_valid(ch_rsp_valid[0]), .ch_rsp_ready(ch_rsp_ready[0]), .ch_rsp_data(ch_rsp_data[0]),
    .busy(busy[0])
  );

  hier_node_dispatch #(.NUM_CHILD(NC), .DATA_W(DW), .SEQ_MODE(1), .TIMEOUT_CYC(64)) u_seq (
    .clk(clk), .rst_n(rst_n),
    .up_req_valid(up_req_valid[1]), .up_req_ready(up_req_ready[1]), .up_req_data(up_req_data[1]),
    .up_rsp_valid(up_rsp_valid[1]), .up_rsp_ready(up_rsp_ready[1]), .up_rsp_data(up_rsp_data[1]),
    .up_rsp_err(up_rsp_err[1]),
    .ch_req_valid(ch_req_valid[1]), .ch_req_ready(ch_req_ready[1]), .ch_req_data(ch_req_data[1]),
    .ch_rsp_valid(ch_rsp_valid[1]), .ch_rsp_ready(ch_rsp_ready[1]), .ch_rsp_data(ch_rsp_data[1]),
    .busy(busy[1])
  );

  // Child configuration (written by the stimulus) and responder state (owned by the model).
  int unsigned   c_delay [2][NC];
  logic [DW-1:0] c_val   [2][NC];
  logic          c_mute  [2][NC];
  int unsigned   c_wait  [2][NC];
  logic          c_armed [2][NC];
  logic [NC-1:0] req_fire [2];
  logic [NC-1:0] rsp_fire [2];

  // Each child answers c_delay cycles after accepting a request; muted children hold their answer.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        ch_rsp_valid[u] = '0;
        ch_rsp_data[u]  = '0;
        req_fire[u]     = '0;
        rsp_fire[u]     = '0;
        for (int i = 0; i < NC; i++) c_armed[u][i] = 1'b0;
      end else begin
        for (int i = 0; i < NC; i++) begin
          if (rsp_fire[u][i]) ch_rsp_valid[u][i] = 1'b0;
          if (req_fire[u][i]) begin
            c_armed[u][i] = 1'b1;
            c_wait[u][i]  = c_delay[u][i];
          end
          if (c_armed[u][i]) begin
            if (c_wait[u][i] != 0) begin
              c_wait[u][i] = c_wait[u][i] - 1;
            end else if (!c_mute[u][i]) begin
              ch_rsp_valid[u][i]          = 1'b1;
              ch_rsp_data[u][i*DW +: DW]  = c_val[u][i];
              c_armed[u][i]               = 1'b0;
            end
          end
        end
        req_fire[u] = ch_req_valid[u] & ch_req_ready[u];
        rsp_fire[u] = ch_rsp_valid[u] & ch_rsp_ready[u];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_child(input int u, input int i, input logic [DW-1:0] v,
                           input int unsigned d, input logic m);
    c_val[u][i]   = v;
    c_delay[u][i] = d;
    c_mute[u][i]  = m;
  endtask

  // Issues one request and checks fan-out, response cycle (handshake = cycle 0), data and err.
  task automatic run_req(input int u, input logic [DW-1:0] req, input int exp_lat,
                         input logic [DW-1:0] exp_data, input logic exp_err, input int hold);
    int            cyc;
    int            order;
    logic [NC-1:0] last;
    logic [NC-1:0] exp_mask;
    cyc = 0;
    while (!up_req_ready[u] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("req_ready", 32'(up_req_ready[u]), 32'd1);
    up_req_valid[u] = 1'b1;
    up_req_data[u]  = req;
    @(negedge clk);
    up_req_valid[u] = 1'b0;
    cyc   = 1;
    order = 0;
    last  = '0;
    while (!up_rsp_valid[u] && cyc < 200) begin
      if (ch_req_valid[u] != '0 && ch_req_valid[u] != last) begin
        exp_mask = (u == 0) ? {NC{1'b1}} : (NC'(1) << order);
        check("ch_req_valid", 32'(ch_req_valid[u]), 32'(exp_mask));
        check("ch_req_data", 32'(ch_req_data[u]), 32'(req));
        order++;
      end
      last = ch_req_valid[u];
      @(negedge clk);
      cyc++;
    end
    check("issue_count", 32'(order), (u == 0) ? 32'd1 : 32'(NC));
    check("rsp_cycle", 32'(cyc), 32'(exp_lat));
    for (int h = 0; h <= hold; h++) begin
      check("rsp_data", 32'(up_rsp_data[u]), 32'(exp_data));
      check("rsp_err", 32'(up_rsp_err[u]), 32'(exp_err));
      if (h < hold) @(negedge clk);
    end
    up_rsp_ready[u] = 1'b1;
    @(negedge clk);
    up_rsp_ready[u] = 1'b0;
    check("rsp_dropped", 32'(up_rsp_valid[u]), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      up_req_valid[u] = 1'b0;
      up_req_data[u]  = '0;
      up_rsp_ready[u] = 1'b0;
      ch_req_ready[u] = '1;
      for (int i = 0; i < NC; i++) set_child(u, i, DW'(i + 1), 0, 1'b0);
    end
    #12;
    for (int u = 0; u < 2; u++) begin
      check("rst_up_req_ready", 32'(up_req_ready[u]), 32'd0);
      check("rst_up_rsp_valid", 32'(up_rsp_valid[u]), 32'd0);
      check("rst_ch_req_valid", 32'(ch_req_valid[u]), 32'd0);
      check("rst_ch_rsp_ready", 32'(ch_rsp_ready[u]), 32'd0);
      check("rst_up_rsp_data", 32'(up_rsp_data[u]), 32'd0);
      check("rst_up_rsp_err", 32'(up_rsp_err[u]), 32'd0);
      check("rst_busy", 32'(busy[u]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready_bc", 32'(up_req_ready[0]), 32'd1);
    check("post_rst_ready_sq", 32'(up_req_ready[1]), 32'd1);

    // Broadcast, zero-wait children returning 1..5.
    run_req(0, 16'h00AA, 3, 16'd15, 1'b0, 0);

    // Modular wrap of the sum.
    set_child(0, 0, 16'hFFFF, 0, 1'b0);
    set_child(0, 1, 16'h0002, 0, 1'b0);
    for (int i = 2; i < NC; i++) set_child(0, i, 16'h0000, 0, 1'b0);
    run_req(0, 16'h1234, 3, 16'h0001, 1'b0, 0);

    // All children answer together; parent back-pressures the response for 4 cycles.
    for (int i = 0; i < NC; i++) set_child(0, i, DW'(16'h0101 * (i + 1)), 0, 1'b0);
    run_req(0, 16'h5555, 3, 16'h0F0F, 1'b0, 4);

    // Timeout: child 3 stays silent, partial sum 1+2+3+5 returned with err.
    for (int i = 0; i < NC; i++) set_child(0, i, DW'(i + 1), 0, (i == 3));
    run_req(0, 16'h0044, 9, 16'd11, 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      check("stale_blocks_ready", 32'(up_req_ready[0]), 32'd0);
      check("stale_busy", 32'(busy[0]), 32'd1);
      check("stale_drain_mask", 32'(ch_rsp_ready[0]), 32'h08);
      @(negedge clk);
    end
    @(posedge clk);
    #1 c_mute[0][3] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!up_req_ready[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("stale_cleared_ready", 32'(up_req_ready[0]), 32'd1);
    check("stale_cleared_mask", 32'(ch_rsp_ready[0]), 32'd0);
    check("stale_cleared_busy", 32'(busy[0]), 32'd0);
    run_req(0, 16'h0055, 3, 16'd15, 1'b0, 0);

    // Reset pulsed while children are still working.
    for (int i = 0; i < NC; i++) set_child(0, i, DW'(i + 1), 3, 1'b0);
    up_req_valid[0] = 1'b1;
    up_req_data[0]  = 16'h0066;
    @(negedge clk);
    up_req_valid[0] = 1'b0;
    @(negedge clk);
    check("pre_rst_collect", 32'(ch_rsp_ready[0]), 32'h1F);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(up_rsp_valid[0]), 32'd0);
    check("mid_rst_ch_req_valid", 32'(ch_req_valid[0]), 32'd0);
    check("mid_rst_ch_rsp_ready", 32'(ch_rsp_ready[0]), 32'd0);
    check("mid_rst_req_ready", 32'(up_req_ready[0]), 32'd0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_err", 32'(up_rsp_err[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_ready", 32'(up_req_ready[0]), 32'd1);
    check("after_rst_no_drain", 32'(ch_rsp_ready[0]), 32'd0);
    check("after_rst_busy", 32'(busy[0]), 32'd0);
    check("after_rst_no_rsp", 32'(up_rsp_valid[0]), 32'd0);
    for (int i = 0; i < NC; i++) set_child(0, i, DW'(i + 1), 0, 1'b0);
    run_req(0, 16'h0077, 3, 16'd15, 1'b0, 0);

    // Sequential node, each child answering after 2 wait cycles.
    set_child(1, 0, 16'h0100, 2, 1'b0);
    set_child(1, 1, 16'h0020, 2, 1'b0);
    set_child(1, 2, 16'h0003, 2, 1'b0);
    set_child(1, 3, 16'h1000, 2, 1'b0);
    set_child(1, 4, 16'h4000, 2, 1'b0);
    run_req(1, 16'h0033, 21, 16'h5123, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
